// File: rtl/player_move_ctrl.sv
// Player move controller: accepts one direction request at a time and bounds-checks
// the target tile. It reads the target tile from the map BRAM, then resolves floor,
// wall, key and door tiles. Consumed tiles are written back as floor. The block also
// tracks the player position and a saturating key count.
module player_move_ctrl #(
  parameter int MAP_WIDTH  = 13,
  parameter int MAP_HEIGHT = 13,
  parameter int COORD_W    = 4,
  parameter int ADDR_W     = 19,
  parameter int TILE_W     = 16,
  parameter int RAM_LAT    = 1,
  parameter int START_X    = 6,
  parameter int START_Y    = 11,
  parameter int KEY_MAX    = 15,
  parameter int TILE_FLOOR = 0,
  parameter int TILE_WALL  = 1,
  parameter int TILE_KEY   = 2,
  parameter int TILE_DOOR  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [1:0]         req_dir,
  output logic               req_ready,
  output logic [ADDR_W-1:0]  map_addr,
  output logic               map_re,
  input  logic [TILE_W-1:0]  map_rdata,
  output logic               map_we,
  output logic [TILE_W-1:0]  map_wdata,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [3:0]         key_count,
  output logic               done,
  output logic [1:0]         done_code
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_DECIDE = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  localparam logic [1:0] CODE_MOVED  = 2'd0;
  localparam logic [1:0] CODE_BLOCK  = 2'd1;
  localparam logic [1:0] CODE_KEY    = 2'd2;
  localparam logic [1:0] CODE_DOOR   = 2'd3;

  localparam logic [COORD_W-1:0] ZERO_C   = {COORD_W{1'b0}};
  localparam logic [COORD_W-1:0] ONE_C    = COORD_W'(1);
  localparam logic [COORD_W-1:0] X_LAST_C = COORD_W'(MAP_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST_C = COORD_W'(MAP_HEIGHT - 1);
  localparam logic [COORD_W-1:0] START_X_C = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] START_Y_C = COORD_W'(START_Y);
  localparam logic [ADDR_W-1:0]  WIDTH_A_C = ADDR_W'(MAP_WIDTH);

  localparam logic [TILE_W-1:0] T_FLOOR_C = TILE_W'(TILE_FLOOR);
  localparam logic [TILE_W-1:0] T_WALL_C  = TILE_W'(TILE_WALL);
  localparam logic [TILE_W-1:0] T_KEY_C   = TILE_W'(TILE_KEY);
  localparam logic [TILE_W-1:0] T_DOOR_C  = TILE_W'(TILE_DOOR);

  localparam logic [3:0] KEY_MAX_C = 4'(KEY_MAX);

  // The wait counter only needs to reach RAM_LAT-1; keep at least one bit.
  localparam int WAIT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST_C = WAIT_W'(RAM_LAT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE_C  = WAIT_W'(1);

  state_t              state_r;
  logic [WAIT_W-1:0]   wait_cnt_r;
  logic [COORD_W-1:0]  tgt_x_r;
  logic [COORD_W-1:0]  tgt_y_r;

  logic [COORD_W-1:0]  tgt_x_s;
  logic [COORD_W-1:0]  tgt_y_s;
  logic                off_map_s;
  logic [ADDR_W-1:0]   tgt_addr_s;

  logic                dec_move_s;
  logic                dec_write_s;
  logic [1:0]          dec_code_s;
  logic [3:0]          key_next_s;

  // Target tile and edge check for the requested direction, from the current position.
  always_comb begin
    tgt_x_s   = pos_x;
    tgt_y_s   = pos_y;
    off_map_s = 1'b0;
    case (req_dir)
      2'd0: begin
        if (pos_y == ZERO_C) begin
          off_map_s = 1'b1;
        end else begin
          tgt_y_s = pos_y - ONE_C;
        end
      end
      2'd1: begin
        if (pos_y == Y_LAST_C) begin
          off_map_s = 1'b1;
        end else begin
          tgt_y_s = pos_y + ONE_C;
        end
      end
      2'd2: begin
        if (pos_x == ZERO_C) begin
          off_map_s = 1'b1;
        end else begin
          tgt_x_s = pos_x - ONE_C;
        end
      end
      2'd3: begin
        if (pos_x == X_LAST_C) begin
          off_map_s = 1'b1;
        end else begin
          tgt_x_s = pos_x + ONE_C;
        end
      end
      default: begin
        off_map_s = 1'b1;
      end
    endcase
    tgt_addr_s = ADDR_W'(tgt_y_s) * WIDTH_A_C + ADDR_W'(tgt_x_s);
  end

  // Classify the tile read back from the map and work out the outcome.
  always_comb begin
    dec_move_s  = 1'b0;
    dec_write_s = 1'b0;
    dec_code_s  = CODE_BLOCK;
    key_next_s  = key_count;
    if (map_rdata == T_FLOOR_C) begin
      dec_move_s = 1'b1;
      dec_code_s = CODE_MOVED;
    end else if (map_rdata == T_WALL_C) begin
      dec_code_s = CODE_BLOCK;
    end else if (map_rdata == T_KEY_C) begin
      dec_move_s  = 1'b1;
      dec_write_s = 1'b1;
      dec_code_s  = CODE_KEY;
      // The key tile is consumed even when the count is already full.
      key_next_s  = (key_count == KEY_MAX_C) ? key_count : key_count + 4'd1;
    end else if (map_rdata == T_DOOR_C) begin
      if (key_count != 4'd0) begin
        dec_write_s = 1'b1;
        dec_code_s  = CODE_DOOR;
        key_next_s  = key_count - 4'd1;
      end else begin
        dec_code_s = CODE_BLOCK;
      end
    end else begin
      // Unknown tile IDs behave as walls.
      dec_code_s = CODE_BLOCK;
    end
  end

  // Request FSM with all map strobes, status outputs and player state registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= {WAIT_W{1'b0}};
      tgt_x_r    <= ZERO_C;
      tgt_y_r    <= ZERO_C;
      req_ready  <= 1'b1;
      map_addr   <= {ADDR_W{1'b0}};
      map_re     <= 1'b0;
      map_we     <= 1'b0;
      map_wdata  <= {TILE_W{1'b0}};
      pos_x      <= START_X_C;
      pos_y      <= START_Y_C;
      key_count  <= 4'd0;
      done       <= 1'b0;
      done_code  <= CODE_MOVED;
    end else begin
      done   <= 1'b0;
      map_we <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            if (off_map_s) begin
              // Edge of the map: answer immediately without touching the BRAM.
              done      <= 1'b1;
              done_code <= CODE_BLOCK;
            end else begin
              tgt_x_r    <= tgt_x_s;
              tgt_y_r    <= tgt_y_s;
              map_addr   <= tgt_addr_s;
              map_re     <= 1'b1;
              wait_cnt_r <= {WAIT_W{1'b0}};
              req_ready  <= 1'b0;
              state_r    <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (wait_cnt_r == WAIT_LAST_C) begin
            map_re  <= 1'b0;
            state_r <= ST_DECIDE;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_ONE_C;
          end
        end
        ST_DECIDE: begin
          // map_addr still holds the target, so the write-back reuses it.
          done      <= 1'b1;
          done_code <= dec_code_s;
          map_we    <= dec_write_s;
          map_wdata <= T_FLOOR_C;
          key_count <= key_next_s;
          if (dec_move_s) begin
            pos_x <= tgt_x_r;
            pos_y <= tgt_y_r;
          end
          state_r <= ST_WB;
        end
        ST_WB: begin
          req_ready <= 1'b1;
          state_r   <= ST_IDLE;
        end
        default: begin
          map_re    <= 1'b0;
          req_ready <= 1'b1;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl. One instance uses a 1-cycle map and the
// other uses a 3-cycle map. Each instance is backed by its own behavioural map
// memory.
module tb_player_move_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_dir = 2'd0;
  logic        use_b = 1'b0;

  logic        ready_a, re_a, we_a, done_a, ready_b, re_b, we_b, done_b;
  logic [18:0] addr_a, addr_b;
  logic [15:0] wdata_a, wdata_b, rd_a, rd_b;
  logic [3:0]  px_a, py_a, keys_a, px_b, py_b, keys_b;
  logic [1:0]  code_a, code_b;

  logic [15:0] mem_a [0:(1<<19)-1];
  logic [15:0] mem_b [0:(1<<19)-1];
  logic [15:0] pipe_b [0:2];

  logic        poke_en = 1'b0;
  logic [1:0]  poke_mask = 2'd0;
  logic [18:0] poke_addr = 19'd0;
  logic [15:0] poke_d = 16'd0;

  int n_total = 0;
  int n_bad = 0;

  int done_cnt, done_off, code, re_cnt, re_off, addr_diff, we_cnt, we_off;
  int re_addr, we_addr, we_data, both_cnt;
  int rdy [0:31];

  logic        m_ready, m_re, m_we, m_done;
  logic [18:0] m_addr;
  logic [15:0] m_wdata;
  logic [3:0]  m_px, m_py, m_keys;
  logic [1:0]  m_code;

  player_move_ctrl dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~use_b), .req_dir(req_dir),
    .req_ready(ready_a), .map_addr(addr_a), .map_re(re_a), .map_rdata(rd_a),
    .map_we(we_a), .map_wdata(wdata_a), .pos_x(px_a), .pos_y(py_a),
    .key_count(keys_a), .done(done_a), .done_code(code_a)
  );

  player_move_ctrl #(.RAM_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid & use_b), .req_dir(req_dir),
    .req_ready(ready_b), .map_addr(addr_b), .map_re(re_b), .map_rdata(rd_b),
    .map_we(we_b), .map_wdata(wdata_b), .pos_x(px_b), .pos_y(py_b),
    .key_count(keys_b), .done(done_b), .done_code(code_b)
  );

  assign m_ready = use_b ? ready_b : ready_a;
  assign m_re    = use_b ? re_b    : re_a;
  assign m_we    = use_b ? we_b    : we_a;
  assign m_done  = use_b ? done_b  : done_a;
  assign m_addr  = use_b ? addr_b  : addr_a;
  assign m_wdata = use_b ? wdata_b : wdata_a;
  assign m_px    = use_b ? px_b    : px_a;
  assign m_py    = use_b ? py_b    : py_a;
  assign m_keys  = use_b ? keys_b  : keys_a;
  assign m_code  = use_b ? code_b  : code_a;

  always #5 clk = ~clk;

  // Map memory with a 1-cycle read latency for instance A.
  always @(posedge clk) begin
    if (poke_en && poke_mask[0]) mem_a[poke_addr] <= poke_d;
    else if (we_a) mem_a[addr_a] <= wdata_a;
    rd_a <= mem_a[addr_a];
  end

  // Map memory with a 3-cycle read latency for instance B.
  always @(posedge clk) begin
    if (poke_en && poke_mask[1]) mem_b[poke_addr] <= poke_d;
    else if (we_b) mem_b[addr_b] <= wdata_b;
    pipe_b[0] <= mem_b[addr_b];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign rd_b = pipe_b[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [1:0] mask, input int addr, input logic [15:0] d);
    poke_en = 1'b1;
    poke_mask = mask;
    poke_addr = 19'(addr);
    poke_d = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one request at a negedge (cycle T0) and log outputs at offsets 1..ncyc.
  task automatic run_req(input logic [1:0] dir, input int hold, input int ncyc, input int rst_at);
    @(negedge clk);
    done_cnt = 0; done_off = -1; code = -1; re_cnt = 0; re_off = -1; re_addr = -1;
    addr_diff = 0; we_cnt = 0; we_off = -1; we_addr = -1; we_data = -1; both_cnt = 0;
    for (int i = 0; i < 32; i++) rdy[i] = -1;
    req_dir = dir;
    req_valid = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (k >= hold) req_valid = 1'b0;
      if (k == rst_at) rst = 1'b1;
      else if (k == rst_at + 1) rst = 1'b0;
      rdy[k] = int'(m_ready);
      if (m_done) begin
        done_cnt++;
        if (done_off < 0) begin
          done_off = k;
          code = int'(m_code);
        end
      end
      if (m_re) begin
        re_cnt++;
        if (re_off < 0) begin
          re_off = k;
          re_addr = int'(m_addr);
        end else if (int'(m_addr) != re_addr) begin
          addr_diff++;
        end
      end
      if (m_we) begin
        we_cnt++;
        we_off = k;
        we_addr = int'(m_addr);
        we_data = int'(m_wdata);
      end
      if (m_re && m_we) both_cnt++;
    end
  endtask

  task automatic exp_req(input string tag, input int e_off, input int e_code, input int e_we,
                         input int e_x, input int e_y, input int e_keys);
    chk({tag, ".done_cnt"}, done_cnt, 1);
    chk({tag, ".done_off"}, done_off, e_off);
    chk({tag, ".code"}, code, e_code);
    chk({tag, ".we_cnt"}, we_cnt, e_we);
    chk({tag, ".pos_x"}, 32'(m_px), e_x);
    chk({tag, ".pos_y"}, 32'(m_py), e_y);
    chk({tag, ".keys"}, 32'(m_keys), e_keys);
    chk({tag, ".re_we"}, both_cnt, 0);
  endtask

  initial begin
    @(negedge clk);
    for (int a = 0; a < 169; a++) poke(2'b11, a, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state, A.
    chk("rst.pos_x", 32'(px_a), 6);
    chk("rst.pos_y", 32'(py_a), 11);
    chk("rst.keys", 32'(keys_a), 0);
    chk("rst.ready", 32'(ready_a), 1);
    chk("rst.strobes", {29'd0, re_a, we_a, done_a}, 0);
    chk("rst.addr", 32'(addr_a), 0);
    chk("rst.wdata", 32'(wdata_a), 0);
    chk("rst.code", 32'(code_a), 0);

    // Plain move right onto floor at (7,11).
    run_req(2'd3, 1, 6, 0);
    exp_req("move_r", 3, 0, 0, 7, 11, 0);
    chk("move_r.re_off", re_off, 1);
    chk("move_r.re_cnt", re_cnt, 1);
    chk("move_r.addr", re_addr, 150);
    chk("move_r.rdy1", rdy[1], 0);
    chk("move_r.rdy3", rdy[3], 0);
    chk("move_r.rdy4", rdy[4], 1);

    // Back to (6,11), then pick up a key at (6,10).
    run_req(2'd2, 1, 6, 0);
    exp_req("move_l", 3, 0, 0, 6, 11, 0);
    poke(2'b01, 136, 16'd2);
    run_req(2'd0, 1, 6, 0);
    exp_req("key1", 3, 2, 1, 6, 10, 1);
    chk("key1.we_off", we_off, 3);
    chk("key1.we_addr", we_addr, 136);
    chk("key1.we_data", we_data, 0);
    chk("key1.mem", 32'(mem_a[136]), 0);

    // Collect keys until the count is full: 2..15.
    for (int i = 0; i < 14; i++) begin
      if (i % 2 == 0) begin
        poke(2'b01, 149, 16'd2);
        run_req(2'd1, 1, 6, 0);
      end else begin
        poke(2'b01, 136, 16'd2);
        run_req(2'd0, 1, 6, 0);
      end
      chk("keyloop.keys", 32'(keys_a), i + 2);
    end
    poke(2'b01, 149, 16'd2);
    run_req(2'd1, 1, 6, 0);
    exp_req("key_sat", 3, 2, 1, 6, 11, 15);
    chk("key_sat.mem", 32'(mem_a[149]), 0);

    // Fresh start: one key, then a door to the left of (6,11).
    pulse_reset();
    chk("rst2.keys", 32'(keys_a), 0);
    poke(2'b01, 136, 16'd2);
    run_req(2'd0, 1, 6, 0);
    exp_req("key_again", 3, 2, 1, 6, 10, 1);
    run_req(2'd1, 1, 6, 0);
    exp_req("down", 3, 0, 0, 6, 11, 1);
    poke(2'b01, 148, 16'd3);
    run_req(2'd2, 1, 6, 0);
    exp_req("door_open", 3, 3, 1, 6, 11, 0);
    chk("door_open.we_addr", we_addr, 148);
    chk("door_open.mem", 32'(mem_a[148]), 0);
    poke(2'b01, 148, 16'd3);
    run_req(2'd2, 1, 6, 0);
    exp_req("door_shut", 3, 1, 0, 6, 11, 0);
    chk("door_shut.mem", 32'(mem_a[148]), 3);

    // Wall and an unknown tile ID to the right.
    poke(2'b01, 150, 16'd1);
    run_req(2'd3, 1, 6, 0);
    exp_req("wall", 3, 1, 0, 6, 11, 0);
    poke(2'b01, 150, 16'd7);
    run_req(2'd3, 1, 6, 0);
    exp_req("odd_tile", 3, 1, 0, 6, 11, 0);

    // Walk to the left edge and bump into it.
    for (int a = 143; a <= 148; a++) poke(2'b01, a, 16'd0);
    for (int i = 0; i < 6; i++) run_req(2'd2, 1, 6, 0);
    chk("walk.pos_x", 32'(px_a), 0);
    run_req(2'd2, 1, 6, 0);
    exp_req("edge_l", 1, 1, 0, 0, 11, 0);
    chk("edge_l.re_cnt", re_cnt, 0);
    chk("edge_l.rdy1", rdy[1], 1);

    // Down to the bottom row, then bump into the bottom edge.
    run_req(2'd1, 1, 6, 0);
    exp_req("to_bottom", 3, 0, 0, 0, 12, 0);
    chk("to_bottom.addr", re_addr, 156);
    run_req(2'd1, 1, 6, 0);
    exp_req("edge_d", 1, 1, 0, 0, 12, 0);
    chk("edge_d.re_cnt", re_cnt, 0);

    // req_valid held high for 10 cycles: acceptances at T0, T0+4, T0+8.
    run_req(2'd3, 10, 14, 0);
    chk("held.done_cnt", done_cnt, 3);
    chk("held.done_off", done_off, 3);
    chk("held.pos_x", 32'(px_a), 3);
    chk("held.pos_y", 32'(py_a), 12);

    // Three-cycle map latency.
    use_b = 1'b1;
    run_req(2'd3, 1, 8, 0);
    exp_req("lat3", 5, 0, 0, 7, 11, 0);
    chk("lat3.re_off", re_off, 1);
    chk("lat3.re_cnt", re_cnt, 3);
    chk("lat3.addr", re_addr, 150);
    chk("lat3.addr_stable", addr_diff, 0);
    chk("lat3.rdy5", rdy[5], 0);
    chk("lat3.rdy6", rdy[6], 1);

    // Reset in the middle of READ aborts a key pickup at (8,11).
    poke(2'b10, 151, 16'd2);
    run_req(2'd3, 1, 8, 2);
    chk("abort.done_cnt", done_cnt, 0);
    chk("abort.we_cnt", we_cnt, 0);
    chk("abort.pos_x", 32'(px_b), 6);
    chk("abort.pos_y", 32'(py_b), 11);
    chk("abort.keys", 32'(keys_b), 0);
    chk("abort.mem", 32'(mem_b[151]), 2);
    chk("abort.ready", 32'(ready_b), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
